// File: rtl/mlu_bootstrapper.sv
// Boot-time LUT image writer: accepts a byte stream and broadcasts each byte to the
// slice lookup memories with a setup/strobe/hold write cycle, then releases N_BOOTED.
module mlu_bootstrapper #(
    parameter int unsigned DEPTH = 12,
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             N_RST,
    input  logic             START,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [DEPTH-1:0] BOOTSTRAP_ADDR,
    output logic [WIDTH-1:0] BOOTSTRAP_DATA,
    output logic             BOOTSTRAP_N_WE,
    output logic             N_BOOTED,
    output logic             BUSY
);

    localparam logic [DEPTH-1:0] LAST_ADDR = '1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } state_t;

    state_t state;

    // Ready is a pure state decode so the source sees no input-to-output path.
    assign IN_READY = (state == LOAD);

    // Write sequencer; address/data only move outside the SETUP..HOLD window.
    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            state          <= IDLE;
            BOOTSTRAP_ADDR <= '0;
            BOOTSTRAP_DATA <= '0;
            BOOTSTRAP_N_WE <= 1'b1;
            N_BOOTED       <= 1'b1;
            BUSY           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        state          <= LOAD;
                        BOOTSTRAP_ADDR <= '0;
                        BUSY           <= 1'b1;
                    end
                end
                LOAD: begin
                    if (IN_VALID) begin
                        BOOTSTRAP_DATA <= IN_DATA;
                        state          <= SETUP;
                    end
                end
                SETUP: begin
                    BOOTSTRAP_N_WE <= 1'b0;
                    state          <= STROBE;
                end
                STROBE: begin
                    BOOTSTRAP_N_WE <= 1'b1;
                    state          <= HOLD;
                end
                HOLD: begin
                    // Terminal compare precedes the increment, so the address never wraps.
                    if (BOOTSTRAP_ADDR == LAST_ADDR) begin
                        state    <= DONE;
                        N_BOOTED <= 1'b0;
                        BUSY     <= 1'b0;
                    end else begin
                        BOOTSTRAP_ADDR <= BOOTSTRAP_ADDR + DEPTH'(1);
                        state          <= LOAD;
                    end
                end
                DONE: begin
                    if (START) begin
                        state          <= LOAD;
                        BOOTSTRAP_ADDR <= '0;
                        N_BOOTED       <= 1'b1;
                        BUSY           <= 1'b1;
                    end
                end
                default: begin
                    state          <= IDLE;
                    BOOTSTRAP_N_WE <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/mlu_bootstrapper.md
Name: mlu_bootstrapper

Overview:
Boot-time writer for the MLU slice lookup memories. It accepts a byte stream (from boot ROM or serial loader) over a valid/ready handshake. It writes each byte into the slice LUTs over the bootstrap bus (BOOTSTRAP_ADDR/BOOTSTRAP_DATA/BOOTSTRAP_N_WE), using an SRAM-safe setup/strobe/hold sequence. After the last address is written, it drives N_BOOTED low to hand the LUTs over to normal ALU operation. The bus is broadcast: all slices share one image and are written in parallel.

Parameters:
DEPTH, 12, LUT address width; image length is 2^DEPTH bytes.
WIDTH, 8, LUT data width.

Ports:
CLK  input  1  system clock, rising edge.
N_RST  input  1  asynchronous active-low reset.
START  input  1  level/pulse; begins a load when sampled high in IDLE or DONE.
IN_DATA  input  WIDTH  image byte from the source.
IN_VALID  input  1  IN_DATA valid.
IN_READY  output  1  bootstrapper can accept a byte this cycle.
BOOTSTRAP_ADDR  output  DEPTH  LUT write address, broadcast to all slices.
BOOTSTRAP_DATA  output  WIDTH  LUT write data, broadcast.
BOOTSTRAP_N_WE  output  1  active-low LUT write strobe.
N_BOOTED  output  1  high while the LUTs are unloaded or being loaded; low once the image is complete (drives slice N_OE).
BUSY  output  1  high from load start until DONE.

Behaviour:
- All outputs are registered; no combinational path from inputs to outputs except IN_READY, which is decoded from state only.
- Reset (async, N_RST=0): state=IDLE, BOOTSTRAP_ADDR=0, BOOTSTRAP_DATA=0, BOOTSTRAP_N_WE=1, N_BOOTED=1, BUSY=0, IN_READY=0.
- States: IDLE, LOAD, SETUP, STROBE, HOLD, DONE.
- IDLE: START=1 -> LOAD. Entering LOAD sets addr=0 and BUSY=1.
- LOAD:
  - IN_READY=1.
  - On IN_VALID&IN_READY, latch IN_DATA into BOOTSTRAP_DATA -> SETUP.
  - With no IN_VALID, stay in LOAD indefinitely. No timeout; stalls are legal.
- SETUP: address and data are stable, N_WE=1, for one cycle -> STROBE.
- STROBE: N_WE=0 for exactly one cycle; address and data are unchanged -> HOLD.
- HOLD: N_WE=1; address and data are unchanged for one cycle.
  - If addr == 2^DEPTH-1 -> DONE.
  - Otherwise addr+1 -> LOAD.
- Throughput: at most one byte per 4 cycles. A full image takes at least 4*2^DEPTH cycles (16384 at default).
- Address arithmetic is DEPTH-bit unsigned. The address never wraps during a load: the terminal compare happens before any increment.
- DONE:
  - N_BOOTED=0, BUSY=0, IN_READY=0.
  - BOOTSTRAP_ADDR holds 2^DEPTH-1 and BOOTSTRAP_DATA holds the last byte.
- START in DONE starts a reload: N_BOOTED returns to 1 on the next edge, addr=0, state LOAD.
- START while BUSY is ignored.
- Extra bytes offered after the final byte are not accepted (IN_READY=0) and are not consumed.
- BOOTSTRAP_N_WE is low only in STROBE. It is never low in two consecutive cycles, and never low while the address or data changes on that edge.
- N_BOOTED goes low only after the HOLD of address 2^DEPTH-1 completes. It is never low with a partially written image.
- Reset mid-load: immediate return to reset values. N_WE deasserts asynchronously and N_BOOTED=1. A new START is required; the partial image is discarded, with no resume.
- START and IN_VALID both high in IDLE: only the state transition happens. The byte is not consumed until the first LOAD cycle.

Test Plan:
- Reset -> all outputs at reset values. Then assert START for 1 cycle -> IN_READY=1 on the next cycle, BUSY=1, N_BOOTED=1, addr=0.
- DEPTH=4, stream 0x00..0x0F with IN_VALID held high -> 16 N_WE pulses, each 1 cycle wide, at addr i with data i, spaced 4 cycles apart. N_BOOTED falls 1 cycle after the addr=0xF HOLD cycle, i.e. 64+1 cycles after START.
- Insert IN_VALID gaps of 0, 1 and 7 cycles -> IN_READY held and no N_WE pulse during each gap. Written data/addr pairs are identical to the gapless run.
- Check outputs at every edge around each strobe -> addr and data constant from SETUP through HOLD. N_WE=0 only in STROBE, and never low on consecutive cycles.
- Assert N_RST after the byte at addr 5 is latched (DEPTH=4) -> N_WE=1 and N_BOOTED=1 immediately. START then reloads from addr 0 and completes normally.
- From DONE (DEPTH=4), pulse START and stream 0xA5 x16 -> N_BOOTED=1 the next cycle, all 16 addresses rewritten with 0xA5, N_BOOTED=0 again. START pulses mid-load are ignored.
